// File: rtl/mpu_regfile.sv
// rtl/mpu_regfile.sv - parametrised MPU register file with sub-word writes and clear sequencer
// Optional: define MPU_REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module mpu_regfile #(
    parameter int  DATA_W   = 64,
    parameter int  ADDR_W   = 5,
    parameter int  RD_PORTS = 3,
    localparam int SEL_W    = $clog2(DATA_W / 8)
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       clr,
    output logic                       ready,
    input  logic [RD_PORTS*ADDR_W-1:0] r_idx,
    output logic [RD_PORTS*DATA_W-1:0] r_data,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          w_idx,
    input  logic [DATA_W-1:0]          w_data,
    input  logic [1:0]                 w_size,
    input  logic [SEL_W-1:0]           w_sel,
    output logic                       w_err
);

    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              w_err_q, w_err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              w_legal;
    logic [DATA_W-1:0] w_merged;

    // Legality check and the byte-lane merge of the write into the addressed register.
    always_comb begin
        int nb;
        int sel;
        nb       = 1 << w_size;
        sel      = int'(w_sel);
        w_legal  = ready_q
                && ((8 << w_size) <= DATA_W)
                && ((sel & (nb - 1)) == 0)
                && ((sel + nb) <= NBYTES);
        w_merged = mem_q[w_idx];
        for (int b = 0; b < NBYTES; b++) begin
            if ((b >= sel) && (b < sel + nb)) begin
                w_merged[b*8 +: 8] = w_data[(b - sel)*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        w_err_d = we && !w_legal;
        mem_d   = mem_q;
        if (we && w_legal) begin
            mem_d[w_idx] = w_merged;
        end
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + ADDR_W'(1);
                if (&cnt_q) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            w_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            w_err_q <= w_err_d;
        end
    end

    // The array has no reset of its own; the clear sweep zeroes it.
    always_ff @(posedge sys_clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        r_data = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            r_data[k*DATA_W +: DATA_W] = mem_q[r_idx[k*ADDR_W +: ADDR_W]];
`ifdef MPU_REGFILE_BYPASS_EN
            if (we && w_legal && (r_idx[k*ADDR_W +: ADDR_W] == w_idx)) begin
                r_data[k*DATA_W +: DATA_W] = w_merged;
            end
`else
`endif
        end
    end

    assign ready = ready_q;
    assign w_err = w_err_q;

endmodule

// File: tb/tb_mpu_regfile.sv
// tb/tb_mpu_regfile.sv - scoreboard bench for mpu_regfile (64-bit and 32-bit instances)
module tb_mpu_regfile;

    logic         sys_clk = 1'b0;
    logic         sys_rst, clr, we, ready, w_err;
    logic [14:0]  r_idx;
    logic [191:0] r_data;
    logic [4:0]   w_idx;
    logic [63:0]  w_data;
    logic [1:0]   w_size;
    logic [2:0]   w_sel;

    logic         rst32, clr32, we32, ready32, w_err32;
    logic [2:0]   r_idx32, w_idx32;
    logic [31:0]  r_data32, w_data32;
    logic [1:0]   w_size32, w_sel32;

    typedef struct {
        int          at;
        int          kind;
        int          port;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        keep[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          base, t, u;
    logic [63:0] act_v;
    bit          seen_err;

    mpu_regfile #(.DATA_W(64), .ADDR_W(5), .RD_PORTS(3)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .ready(ready),
        .r_idx(r_idx), .r_data(r_data), .we(we), .w_idx(w_idx),
        .w_data(w_data), .w_size(w_size), .w_sel(w_sel), .w_err(w_err)
    );

    mpu_regfile #(.DATA_W(32), .ADDR_W(3), .RD_PORTS(1)) u_dut32 (
        .sys_clk(sys_clk), .sys_rst(rst32), .clr(clr32), .ready(ready32),
        .r_idx(r_idx32), .r_data(r_data32), .we(we32), .w_idx(w_idx32),
        .w_data(w_data32), .w_size(w_size32), .w_sel(w_sel32), .w_err(w_err32)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(int kind, int port);
        case (kind)
            0:       return r_data[port*64 +: 64];
            1:       return {63'd0, ready};
            2:       return {63'd0, w_err};
            3:       return {32'd0, r_data32};
            4:       return {63'd0, w_err32};
            default: return {63'd0, ready32};
        endcase
    endfunction

    // Monitor: compares every expectation due in this cycle, flags unexpected w_err pulses.
    always @(negedge sys_clk) begin
        seen_err = 1'b0;
        keep.delete();
        foreach (sb[i]) begin
            if (sb[i].at == cyc) begin
                act_v  = actual(sb[i].kind, sb[i].port);
                checks = checks + 1;
                if (sb[i].kind == 2) seen_err = 1'b1;
                if (act_v !== sb[i].exp) begin
                    errors = errors + 1;
                    $display("FAIL %s @cycle %0d: got %h expected %h", sb[i].name, cyc, act_v, sb[i].exp);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
        if (w_err === 1'b1 && !seen_err) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_w_err @cycle %0d: got 1 expected 0", cyc);
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_at(int at, int kind, int port, logic [63:0] exp, string name);
        exp_t e;
        e.at   = at;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic set_ridx(int p, logic [4:0] idx);
        r_idx[p*5 +: 5] = idx;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        sys_rst = 1'b1; clr = 1'b0; we = 1'b0; w_idx = '0; w_data = '0;
        w_size = '0; w_sel = '0; r_idx = '0;
        rst32 = 1'b1; clr32 = 1'b0; we32 = 1'b0; w_idx32 = '0; w_data32 = '0;
        w_size32 = '0; w_sel32 = '0; r_idx32 = '0;
        step(); step(); step();

        // 1: reset release, clear sweep timing, zeroed array
        sys_rst = 1'b0; rst32 = 1'b0;
        base = cyc;
        for (int i = 0; i < 32; i++) expect_at(base + i, 1, 0, 64'd0, "t1_ready_low");
        expect_at(base + 32, 1, 0, 64'd1, "t1_ready_high");
        expect_at(base, 2, 0, 64'd0, "t1_werr_reset");
        expect_at(base + 7, 5, 0, 64'd0, "t1_ready32_low");
        expect_at(base + 8, 5, 0, 64'd1, "t1_ready32_high");
        repeat (32) step();
        set_ridx(0, 5'd0); set_ridx(1, 5'd1); set_ridx(2, 5'd2);
        for (int p = 0; p < 3; p++) expect_at(cyc, 0, p, 64'd0, "t1_read_zero");

        // 2: full write then 16-bit write at byte 6
        we = 1'b1; w_idx = 5'd0; w_data = 64'haaaa_aaaa_aaaa_aaaa; w_size = 2'b11; w_sel = 3'd0;
        expect_at(cyc + 1, 2, 0, 64'd0, "t2_werr_full");
        step();
        w_data = 64'hbbbb; w_size = 2'b01; w_sel = 3'd6;
        expect_at(cyc + 1, 2, 0, 64'd0, "t2_werr_half");
        step();
        we = 1'b0;
        set_ridx(0, 5'd0); set_ridx(1, 5'd0); set_ridx(2, 5'd1);
        expect_at(cyc, 0, 0, 64'hbbbb_aaaa_aaaa_aaaa, "t2_r0_port0");
        expect_at(cyc, 0, 1, 64'hbbbb_aaaa_aaaa_aaaa, "t2_r0_port1");
        expect_at(cyc, 0, 2, 64'd0, "t2_r1_port2");
        step();

        // 3: misaligned writes rejected with single-cycle w_err
        we = 1'b1; w_idx = 5'd3; w_data = 64'hffff; w_size = 2'b01; w_sel = 3'd3;
        expect_at(cyc + 1, 2, 0, 64'd1, "t3_werr_h_sel3");
        step();
        we = 1'b0;
        expect_at(cyc + 1, 2, 0, 64'd0, "t3_werr_drop1");
        step();
        we = 1'b1; w_data = 64'hffff_ffff; w_size = 2'b10; w_sel = 3'd2;
        expect_at(cyc + 1, 2, 0, 64'd1, "t3_werr_w_sel2");
        step();
        we = 1'b0; set_ridx(0, 5'd3);
        expect_at(cyc + 1, 2, 0, 64'd0, "t3_werr_drop2");
        expect_at(cyc, 0, 0, 64'd0, "t3_r3_zero");
        step();

        // 4: clear request, write during clear, clr ignored mid-sweep
        we = 1'b1; w_idx = 5'd5; w_data = 64'h1122_3344_5566_7788; w_size = 2'b11; w_sel = 3'd0;
        step();
        we = 1'b0; set_ridx(0, 5'd5); clr = 1'b1; t = cyc;
        expect_at(t, 0, 0, 64'h1122_3344_5566_7788, "t4_r5_written");
        expect_at(t, 1, 0, 64'd1, "t4_ready_before");
        for (int i = 1; i <= 32; i++) expect_at(t + i, 1, 0, 64'd0, "t4_ready_low");
        expect_at(t + 33, 1, 0, 64'd1, "t4_ready_back");
        step();
        clr = 1'b0;
        repeat (4) step();
        we = 1'b1; w_idx = 5'd1; w_data = 64'hdead; w_size = 2'b11; w_sel = 3'd0;
        expect_at(cyc + 1, 2, 0, 64'd1, "t4_werr_midclear");
        step();
        we = 1'b0; set_ridx(1, 5'd1);
        expect_at(cyc, 0, 1, 64'd0, "t4_r1_unchanged");
        repeat (4) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        while (cyc < t + 33) step();
        set_ridx(0, 5'd5); set_ridx(1, 5'd1); set_ridx(2, 5'd0);
        expect_at(cyc, 0, 0, 64'd0, "t4_r5_cleared");
        expect_at(cyc, 0, 1, 64'd0, "t4_r1_cleared");
        expect_at(cyc, 0, 2, 64'd0, "t4_r0_cleared");

        // 5: reset at clear cycle 10 restarts the sweep and clears w_err
        clr = 1'b1; u = cyc;
        step();
        clr = 1'b0;
        repeat (10) step();
        sys_rst = 1'b1; we = 1'b1; w_idx = 5'd2; w_data = 64'd1; w_size = 2'b00; w_sel = 3'd0;
        step();
        sys_rst = 1'b0; we = 1'b0; base = cyc;
        expect_at(base, 2, 0, 64'd0, "t5_werr_reset");
        for (int i = 0; i < 32; i++) expect_at(base + i, 1, 0, 64'd0, "t5_ready_low");
        expect_at(base + 32, 1, 0, 64'd1, "t5_ready_high");
        while (cyc < base + 32) step();

        // 6: byte write to r7 with concurrent read; 32-bit instance rejects size 11
        we = 1'b1; w_idx = 5'd7; w_data = 64'hff; w_size = 2'b00; w_sel = 3'd7; set_ridx(0, 5'd7);
        we32 = 1'b1; w_idx32 = 3'd7; w_data32 = 32'hff; w_size32 = 2'b00; w_sel32 = 2'd3; r_idx32 = 3'd7;
`ifdef MPU_REGFILE_BYPASS_EN
        expect_at(cyc, 0, 0, 64'hff00_0000_0000_0000, "t6_same_cycle");
        expect_at(cyc, 3, 0, 64'hff00_0000, "t6_32_same_cycle");
`else
        expect_at(cyc, 0, 0, 64'd0, "t6_same_cycle");
        expect_at(cyc, 3, 0, 64'd0, "t6_32_same_cycle");
`endif
        expect_at(cyc + 1, 2, 0, 64'd0, "t6_werr_legal");
        expect_at(cyc + 1, 4, 0, 64'd0, "t6_32_werr_legal");
        step();
        w_data = 64'h1234; w_size = 2'b01; w_sel = 3'd7;
        w_idx32 = 3'd2; w_data32 = 32'hffff_ffff; w_size32 = 2'b11; w_sel32 = 2'd0;
        expect_at(cyc, 0, 0, 64'hff00_0000_0000_0000, "t6_next_cycle");
        expect_at(cyc, 3, 0, 64'hff00_0000, "t6_32_next_cycle");
        expect_at(cyc + 1, 2, 0, 64'd1, "t6_werr_rejected");
        expect_at(cyc + 1, 4, 0, 64'd1, "t6_32_werr_size64");
        step();
        we = 1'b0; we32 = 1'b0; r_idx32 = 3'd2;
        expect_at(cyc, 0, 0, 64'hff00_0000_0000_0000, "t6_r7_kept");
        expect_at(cyc, 3, 0, 64'd0, "t6_32_r2_unchanged");
        expect_at(cyc + 1, 4, 0, 64'd0, "t6_32_werr_drop");
        step(); step(); step();

        foreach (sb[i]) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unchecked_%s: got none expected %h at cycle %0d", sb[i].name, sb[i].exp, sb[i].at);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpu_regfile.md
Name: mpu_regfile

Overview:
Parametrised successor of the MPU register file. It provides a configurable depth, data width and read-port count, and one write port with sized, byte-offset sub-word writes. A built-in clear sequencer zeroes the array after reset or on request. It sits between the MPU decode stage (read indices) and the execute/writeback stage (write port).

Parameters:
DATA_W, 64, register width in bits; must be a power of two, minimum 16.
ADDR_W, 5, index width; depth = 2**ADDR_W registers.
RD_PORTS, 3, number of independent asynchronous read ports, 1..8.
SEL_W (derived localparam), log2(DATA_W/8), width of the byte-offset select.

Ports:
sys_clk  in  1  clock; all state updates on the rising edge.
sys_rst  in  1  synchronous, active-high reset.
clr  in  1  one-cycle pulse that starts a full array clear.
ready  out  1  high when the array is usable (no clear in progress).
r_idx  in  RD_PORTS*ADDR_W  packed read indices; port k is at [k*ADDR_W +: ADDR_W].
r_data  out  RD_PORTS*DATA_W  packed read data; port k is at [k*DATA_W +: DATA_W].
we  in  1  write enable.
w_idx  in  ADDR_W  write index.
w_data  in  DATA_W  write data, right-aligned; the low (8<<w_size) bits are used.
w_size  in  2  write size: 00 = 8, 01 = 16, 10 = 32, 11 = 64 bits.
w_sel  in  SEL_W  byte offset of the write within the register.
w_err  out  1  registered one-cycle pulse flagging a rejected write.

Behaviour:
- Storage: 2**ADDR_W x DATA_W flops. The array is not reset directly; the clear sequencer zeroes it.
- Reads:
  - Combinational: r_data[k] = reg[r_idx[k]], with no latency.
  - Any number of ports may read the same index.
- Write legality. A write is legal when all of the following hold:
  - (8<<w_size) <= DATA_W.
  - w_sel is a multiple of (1<<w_size), i.e. naturally aligned.
  - w_sel + (1<<w_size) <= DATA_W/8.
  - ready = 1.
- Legal write: on the clock edge, bytes w_sel .. w_sel+(1<<w_size)-1 of reg[w_idx] take w_data[(8<<w_size)-1:0]. Other bytes are unchanged. There is no sign or zero extension.
- Illegal write with we = 1: the array is unchanged, and w_err = 1 on the following cycle for exactly one cycle.
- w_err is 0 when we = 0.
- Clear sequencer FSM, states IDLE and CLEAR, with an ADDR_W-bit counter cnt:
  - sys_rst = 1: state <= CLEAR, cnt <= 0, w_err <= 0, ready <= 0. Reset mid-clear restarts the clear from index 0.
  - IDLE with clr = 1: state <= CLEAR, cnt <= 0, ready <= 0 on the next edge.
  - CLEAR, each cycle: reg[cnt] <= 0, cnt <= cnt+1. At cnt = 2**ADDR_W-1, state <= IDLE and ready <= 1. A clear therefore takes exactly 2**ADDR_W cycles, and the counter wraps naturally.
  - clr asserted during CLEAR is ignored; the sweep is not restarted.
- Writes during CLEAR are rejected: the array is unchanged and w_err pulses.
- Reads during CLEAR return the current array contents, which may be partially cleared. Consumers must wait for ready.
- Reset values: ready = 0, w_err = 0. r_data is undefined until the first clear completes.
- clr and we in the same IDLE cycle: the write is applied first, and the clear then overwrites it.

Optional Feature:
MPU_REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. When we = 1, the write is legal, and r_idx[k] == w_idx, r_data[k] in that same cycle shows reg[w_idx] with the new bytes merged in (combinational). Forwarding applies independently on every port.
- Not defined: r_data[k] shows the old contents until the edge; the new value is visible from the next cycle.
- Rejected writes are never forwarded in either case.

Test Plan:
1. Reset, then hold 32 cycles -> ready = 0 for cycles 0..31 after reset release and 1 from cycle 32; all three ports read 0 for indices 0, 1, 2.
2. Full write r0 <= 0xaaaaaaaaaaaaaaaa (size 11, sel 0), then a 16-bit write r0 of 0xbbbb at sel 6 -> r0 = 0xbbbbaaaaaaaaaaaa; r_idx port 0/1/2 = 0/0/1 reads r0, r0 and 0.
3. Misaligned writes (size 01 at sel 3; size 10 at sel 2) -> w_err pulses high for one cycle each; r3 stays 0.
4. Write r5 = 0x1122334455667788, then pulse clr -> ready drops; r5 reads 0 once ready returns 33 cycles later; a write issued mid-clear -> w_err = 1 and no array change.
5. sys_rst asserted at clear cycle 10 -> clear restarts; ready returns exactly 32 cycles after reset deasserts.
6. Read r7 while writing r7 <= 0xff (size 00, sel 7) -> with MPU_REGFILE_BYPASS_EN, the same cycle shows 0xff00000000000000; without it, the same cycle shows 0 and the next cycle shows 0xff00000000000000. Repeat with DATA_W = 32, where size 11 is rejected with w_err.
